// File: rtl/frame_writer.sv
// frame_writer: Avalon-ST 16-bit video sink that writes each frame to memory through an Avalon-MM write master.
// Optional build macro FRAME_WRITER_IRQ_EN adds the irq output and the interrupt register at address 4.
`timescale 1ns/1ps
module frame_writer #(
    parameter int XRES       = 640,
    parameter int YRES       = 480,
    parameter int FIFO_DEPTH = 512,
    parameter int FIFO_FULL  = 448
) (
    input  logic        clock,
    input  logic        clock_areset_n,
    input  logic [3:0]  s_address,
    output logic [31:0] s_readdata,
    input  logic [31:0] s_writedata,
    input  logic        s_read,
    input  logic        s_write,
    output logic        s_waitrequest,
    output logic [31:0] m_address,
    output logic [1:0]  m_byteenable,
    output logic [15:0] m_writedata,
    output logic        m_write,
    input  logic        m_waitrequest,
    output logic        st_ready,
    input  logic        st_valid,
    input  logic        st_sop,
    input  logic        st_eop,
    input  logic [15:0] st_data
`ifdef FRAME_WRITER_IRQ_EN
    ,
    output logic        irq
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int UW = AW + 1;
    localparam logic [UW-1:0] FULL_LVL = UW'(FIFO_FULL);
    localparam logic [15:0]   XRES_W   = 16'(XRES);
    localparam logic [15:0]   YRES_W   = 16'(YRES);
    localparam logic [31:0]   NPIX     = 32'(XRES * YRES);

    typedef enum logic [1:0] {S_IDLE, S_HDR1, S_PIX, S_DISC} st_state_t;
    typedef enum logic [1:0] {W_IDLE, W_WRITE, W_DONE} wr_state_t;

    logic        go_q, go_rewr_q, reset_flag_q, run_q, rd_phase_q;
    logic        hdr_err_q, long_err_q, short_err_q;
    logic [31:0] wp_q, s_readdata_q, rdata;
    logic [15:0] fcnt_q;
    logic        wr_ctl, wr_go, soft_rst, busy;

    logic [16:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [UW-1:0] usedw_q;
    logic          fifo_empty, push, pop;
    logic [16:0]   push_word, head;

    st_state_t   st_q, st_d;
    logic        hdr_bad_q, hdr_bad_d;
    logic [31:0] pix_cnt_q, pix_cnt_d, pix_next;
    logic        beat, set_hdr, set_short, set_long;

    wr_state_t   ws_q, ws_d;
    logic [31:0] m_address_q, m_address_d;
    logic [15:0] m_writedata_q, m_writedata_d;
    logic        m_write_q, m_write_d, m_eop_q, m_eop_d, accept, frame_done;

    assign wr_ctl        = s_write && (s_address == 4'd0);
    assign wr_go         = wr_ctl && s_writedata[0];
    assign soft_rst      = s_write && (s_address == 4'd1) && s_writedata[0];
    assign busy          = (ws_q != W_IDLE);
    assign s_waitrequest = s_read && !rd_phase_q;
    assign s_readdata    = s_readdata_q;

    assign m_address    = m_address_q;
    assign m_writedata  = m_writedata_q;
    assign m_write      = m_write_q;
    assign m_byteenable = {2{m_write_q}};

`ifdef FRAME_WRITER_IRQ_EN
    logic irq_en_q, irq_pend_q;
    assign irq = irq_pend_q && irq_en_q;

    always_ff @(posedge clock or negedge clock_areset_n) begin
        if (!clock_areset_n) begin
            irq_en_q   <= 1'b0;
            irq_pend_q <= 1'b0;
        end else begin
            if (s_write && (s_address == 4'd4)) irq_en_q <= s_writedata[0];
            if (frame_done)                                             irq_pend_q <= 1'b1;
            else if (s_write && (s_address == 4'd4) && s_writedata[1]) irq_pend_q <= 1'b0;
        end
    end
`endif

    always_comb begin
        rdata = '0;
        case (s_address)
            4'd0:    rdata = {27'd0, hdr_err_q, long_err_q, short_err_q, busy, go_q};
            4'd2:    rdata = wp_q;
            4'd3:    rdata = {16'd0, fcnt_q};
`ifdef FRAME_WRITER_IRQ_EN
            4'd4:    rdata = {30'd0, irq_pend_q, irq_en_q};
`endif
            default: rdata = '0;
        endcase
    end

    // go stays set at end of frame only if software re-armed it while the frame was in flight
    always_ff @(posedge clock or negedge clock_areset_n) begin
        if (!clock_areset_n) begin
            run_q        <= 1'b0;
            reset_flag_q <= 1'b0;
            rd_phase_q   <= 1'b0;
            s_readdata_q <= '0;
            wp_q         <= '0;
            fcnt_q       <= '0;
            go_q         <= 1'b0;
            go_rewr_q    <= 1'b0;
            hdr_err_q    <= 1'b0;
            long_err_q   <= 1'b0;
            short_err_q  <= 1'b0;
        end else begin
            run_q        <= 1'b1;
            reset_flag_q <= soft_rst;
            rd_phase_q   <= s_read && !rd_phase_q;
            if (s_read && !rd_phase_q) s_readdata_q <= rdata;
            if (s_write && (s_address == 4'd2)) wp_q <= s_writedata;
            if (frame_done) fcnt_q <= fcnt_q + 16'd1;
            if (wr_go)                                 go_q <= 1'b1;
            else if ((ws_q == W_DONE) && !go_rewr_q)   go_q <= 1'b0;
            if (reset_flag_q || (ws_q == W_DONE))      go_rewr_q <= 1'b0;
            else if (wr_go && busy)                    go_rewr_q <= 1'b1;
            if (reset_flag_q) begin
                hdr_err_q   <= 1'b0;
                long_err_q  <= 1'b0;
                short_err_q <= 1'b0;
            end else begin
                hdr_err_q   <= set_hdr   || (hdr_err_q   && !(wr_ctl && s_writedata[4]));
                long_err_q  <= set_long  || (long_err_q  && !(wr_ctl && s_writedata[3]));
                short_err_q <= set_short || (short_err_q && !(wr_ctl && s_writedata[2]));
            end
        end
    end

    assign fifo_empty = (usedw_q == '0);
    assign head       = mem[rd_ptr_q];

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr_q] <= push_word;
    end

    always_ff @(posedge clock or negedge clock_areset_n) begin
        if (!clock_areset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            usedw_q  <= '0;
        end else if (reset_flag_q) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            usedw_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (push && !pop)      usedw_q <= usedw_q + UW'(1);
            else if (pop && !push) usedw_q <= usedw_q - UW'(1);
        end
    end

    assign st_ready = run_q && !reset_flag_q && ((st_q != S_PIX) || (usedw_q < FULL_LVL));
    assign beat     = st_valid && st_ready;
    assign pix_next = pix_cnt_q + 32'd1;

    // the last pixel of a full frame always carries eop so the writer closes the frame
    always_comb begin
        st_d      = st_q;
        hdr_bad_d = hdr_bad_q;
        pix_cnt_d = pix_cnt_q;
        push      = 1'b0;
        push_word = {st_eop, st_data};
        set_hdr   = 1'b0;
        set_short = 1'b0;
        set_long  = 1'b0;
        case (st_q)
            S_IDLE: begin
                if (beat && st_sop) begin
                    hdr_bad_d = (st_data != XRES_W);
                    set_hdr   = (st_data != XRES_W);
                    st_d      = S_HDR1;
                end
            end
            S_HDR1: begin
                if (beat) begin
                    set_hdr   = (st_data != YRES_W);
                    pix_cnt_d = '0;
                    if (st_eop)                               st_d = S_IDLE;
                    else if (hdr_bad_q || (st_data != YRES_W)) st_d = S_DISC;
                    else                                      st_d = S_PIX;
                end
            end
            S_PIX: begin
                if (beat && st_sop) begin
                    set_short = 1'b1;
                    hdr_bad_d = 1'b0;
                    st_d      = S_HDR1;
                end else if (beat) begin
                    push      = 1'b1;
                    pix_cnt_d = pix_next;
                    if (pix_next == NPIX) begin
                        push_word[16] = 1'b1;
                        if (st_eop) begin
                            st_d = S_IDLE;
                        end else begin
                            st_d     = S_DISC;
                            set_long = 1'b1;
                        end
                    end else if (st_eop) begin
                        set_short = 1'b1;
                        st_d      = S_IDLE;
                    end
                end
            end
            S_DISC: begin
                if (beat && st_sop) begin
                    hdr_bad_d = 1'b0;
                    st_d      = S_HDR1;
                end else if (beat && st_eop) begin
                    st_d = S_IDLE;
                end
            end
            default: st_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge clock_areset_n) begin
        if (!clock_areset_n) begin
            st_q      <= S_IDLE;
            hdr_bad_q <= 1'b0;
            pix_cnt_q <= '0;
        end else if (reset_flag_q) begin
            st_q      <= S_IDLE;
            hdr_bad_q <= 1'b0;
            pix_cnt_q <= '0;
        end else begin
            st_q      <= st_d;
            hdr_bad_q <= hdr_bad_d;
            pix_cnt_q <= pix_cnt_d;
        end
    end

    assign accept = m_write_q && !m_waitrequest && !reset_flag_q;

    always_comb begin
        ws_d          = ws_q;
        m_address_d   = m_address_q;
        m_writedata_d = m_writedata_q;
        m_write_d     = m_write_q;
        m_eop_d       = m_eop_q;
        pop           = 1'b0;
        frame_done    = 1'b0;
        case (ws_q)
            W_IDLE: begin
                if (go_q && !fifo_empty) begin
                    m_address_d = wp_q;
                    ws_d        = W_WRITE;
                end
            end
            W_WRITE: begin
                if (accept) begin
                    m_address_d = m_address_q + 32'd2;
                    m_write_d   = 1'b0;
                end
                if (accept && m_eop_q) begin
                    frame_done = 1'b1;
                    ws_d       = W_DONE;
                end else if ((!m_write_q || accept) && !fifo_empty) begin
                    pop           = 1'b1;
                    m_writedata_d = head[15:0];
                    m_eop_d       = head[16];
                    m_write_d     = 1'b1;
                end
            end
            W_DONE:  ws_d = W_IDLE;
            default: ws_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge clock_areset_n) begin
        if (!clock_areset_n) begin
            ws_q          <= W_IDLE;
            m_address_q   <= '0;
            m_writedata_q <= '0;
            m_write_q     <= 1'b0;
            m_eop_q       <= 1'b0;
        end else if (reset_flag_q) begin
            ws_q      <= W_IDLE;
            m_write_q <= 1'b0;
            m_eop_q   <= 1'b0;
        end else begin
            ws_q          <= ws_d;
            m_address_q   <= m_address_d;
            m_writedata_q <= m_writedata_d;
            m_write_q     <= m_write_d;
            m_eop_q       <= m_eop_d;
        end
    end
endmodule
